serial_frame_receiver: RTL

- Serial-in / parallel-out receiver: the receiving end of a bit-serial link whose transmitter is a universal shift register in shift mode.
- Detects a start bit, shifts in WIDTH data bits, checks the stop bit, then presents the word on a parallel output with a one-cycle valid strobe.
- Bit rate is set by an external sample strobe, so the block runs at one bit per clock or slower.

---
 rtl/serial_frame_receiver.sv | 88 ++++++++
 1 files changed

// File: rtl/serial_frame_receiver.sv
// Bit-serial frame receiver: start bit, WIDTH data bits, stop bit, gated by an external sample strobe.
// The good word is presented on DATAOUT with a one-cycle data_valid pulse; a low stop bit pulses frame_error.
module serial_frame_receiver #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             sample_en,
    output logic [WIDTH-1:0] DATAOUT,
    output logic             data_valid,
    output logic             frame_error,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        ERR_WAIT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;

    // NOTE: every register here is written with <= so all of them update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            DATAOUT     <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Strobes default low on every edge so each lasts exactly one clock.
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (sample_en) begin
                case (state)
                    IDLE: begin
                        if (!serial_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (MSB_FIRST)
                            shift_reg <= {shift_reg[WIDTH-2:0], serial_in};
                        else
                            shift_reg <= {serial_in, shift_reg[WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT)
                            state <= STOP;
                    end
                    STOP: begin
                        busy <= 1'b0;
                        if (serial_in) begin
                            DATAOUT    <= shift_reg;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= ERR_WAIT;
                        end
                    end
                    ERR_WAIT: begin
                        // A held-low break line must go high before a new start bit counts.
                        if (serial_in)
                            state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
